// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul tile engine and its accumulator cells.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    COMPUTE,
    OUTPUT
  } state_t;

  // Bit positions of the individual error causes folded into err_reg.
  localparam int ERR_N      = 3;
  localparam int ERR_CFG    = 0;
  localparam int ERR_A_LAST = 1;
  localparam int ERR_B_LAST = 2;

  function automatic int ck_width(input int k_max);
    return $clog2(k_max + 1);
  endfunction

endpackage

// File: rtl/matmul_pe.sv
// One accumulator cell: adds the signed product a*b into acc on each enabled cycle.
module matmul_pe #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic                     clear,
  input  logic                     en,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int EXT_W  = (ACC_W > PROD_W) ? ACC_W : PROD_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [EXT_W-1:0]  prod_ext;

  // Sign-extend (or keep the low bits of) the full product; the sum wraps.
  assign prod     = PROD_W'(a) * PROD_W'(b);
  assign prod_ext = EXT_W'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/matmul_tile_engine.sv
// M x N output-tile matrix multiply: streams in A and B, runs K MAC steps, streams out C.
module matmul_tile_engine
  import matmul_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int M      = 2,
  parameter int N      = 2,
  parameter int K_MAX  = 8,
  localparam int CK_W  = ck_width(K_MAX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_axis_a_tdata,
  input  logic              s_axis_a_tvalid,
  output logic              s_axis_a_tready,
  input  logic              s_axis_a_tlast,
  input  logic [DATA_W-1:0] s_axis_b_tdata,
  input  logic              s_axis_b_tvalid,
  output logic              s_axis_b_tready,
  input  logic              s_axis_b_tlast,
  output logic [ACC_W-1:0]  m_axis_c_tdata,
  output logic              m_axis_c_tvalid,
  input  logic              m_axis_c_tready,
  output logic              m_axis_c_tlast,
  input  logic [CK_W-1:0]   cfg_k,
  input  logic              start,
  input  logic              clr_done,
  input  logic              irq_en,
  output logic              busy,
  output logic              done_pulse,
  output logic              done_reg,
  output logic              err_reg,
  output logic              irq
);

  localparam int MI_W = $clog2(M);
  localparam int NI_W = $clog2(N);
  localparam int KI_W = $clog2(K_MAX);
  localparam int CI_W = $clog2(M * N);
  localparam int CW_A = (CK_W > $clog2(M + 1)) ? CK_W : $clog2(M + 1);
  localparam int CW   = (CW_A > $clog2(N + 1)) ? CW_A : $clog2(N + 1);

  state_t state, state_nxt;

  logic [CK_W-1:0] k_r, k_cnt;
  logic [CW-1:0]   row_cnt, col_cnt, k_last_w;
  logic [CI_W-1:0] c_cnt;
  logic [KI_W-1:0] k_idx;
  logic            c_valid, cfg_ok, start_ok, pe_en;
  logic            a_hs, b_hs, c_hs, a_final, b_final, k_final, c_final;
  logic [ERR_N-1:0] err_event;

  logic signed [DATA_W-1:0] a_buf [M][K_MAX];
  logic signed [DATA_W-1:0] b_buf [K_MAX][N];
  logic signed [ACC_W-1:0]  acc   [M*N];

  assign cfg_ok   = (cfg_k != '0) && (cfg_k <= CK_W'(K_MAX));
  assign start_ok = (state == IDLE) && start && cfg_ok;
  assign k_last_w = CW'(k_r) - CW'(1);
  assign a_final  = (row_cnt == CW'(M - 1)) && (col_cnt == k_last_w);
  assign b_final  = (row_cnt == k_last_w) && (col_cnt == CW'(N - 1));
  assign k_final  = (k_cnt == k_r - CK_W'(1));
  assign c_final  = (c_cnt == CI_W'(M * N - 1));
  assign k_idx    = k_cnt[KI_W-1:0];

  assign a_hs = s_axis_a_tvalid && s_axis_a_tready;
  assign b_hs = s_axis_b_tvalid && s_axis_b_tready;
  assign c_hs = c_valid && m_axis_c_tready;

  // tlast is only cross-checked against the beat count; it never steers the FSM.
  assign err_event[ERR_CFG]    = (state == IDLE) && start && !cfg_ok;
  assign err_event[ERR_A_LAST] = a_hs && (s_axis_a_tlast != a_final);
  assign err_event[ERR_B_LAST] = b_hs && (s_axis_b_tlast != b_final);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok)          state_nxt = LOAD_A;
      LOAD_A:  if (a_hs && a_final)   state_nxt = LOAD_B;
      LOAD_B:  if (b_hs && b_final)   state_nxt = COMPUTE;
      COMPUTE: if (k_final)           state_nxt = OUTPUT;
      OUTPUT:  if (c_hs && c_final)   state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_axis_a_tready = 1'b0;
    s_axis_b_tready = 1'b0;
    pe_en           = 1'b0;
    busy            = (state != IDLE);
    case (state)
      LOAD_A:  s_axis_a_tready = 1'b1;
      LOAD_B:  s_axis_b_tready = 1'b1;
      COMPUTE: pe_en           = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_r     <= '0;
      k_cnt   <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      for (int i = 0; i < M; i++)
        for (int k = 0; k < K_MAX; k++) a_buf[i][k] <= '0;
      for (int k = 0; k < K_MAX; k++)
        for (int j = 0; j < N; j++) b_buf[k][j] <= '0;
    end else begin
      case (state)
        IDLE: if (start_ok) begin
          k_r     <= cfg_k;
          k_cnt   <= '0;
          row_cnt <= '0;
          col_cnt <= '0;
        end
        LOAD_A: if (a_hs) begin
          a_buf[row_cnt[MI_W-1:0]][col_cnt[KI_W-1:0]] <= s_axis_a_tdata;
          if (col_cnt == k_last_w) begin
            col_cnt <= '0;
            row_cnt <= a_final ? '0 : row_cnt + CW'(1);
          end else begin
            col_cnt <= col_cnt + CW'(1);
          end
        end
        LOAD_B: if (b_hs) begin
          b_buf[row_cnt[KI_W-1:0]][col_cnt[NI_W-1:0]] <= s_axis_b_tdata;
          if (col_cnt == CW'(N - 1)) begin
            col_cnt <= '0;
            row_cnt <= b_final ? '0 : row_cnt + CW'(1);
          end else begin
            col_cnt <= col_cnt + CW'(1);
          end
        end
        COMPUTE: k_cnt <= k_final ? '0 : k_cnt + CK_W'(1);
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      matmul_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a_buf[i][k_idx]),
        .b     (b_buf[k_idx][j]),
        .clear (start_ok),
        .en    (pe_en),
        .acc   (acc[i*N+j])
      );
    end
  end

  // The accumulators are frozen in OUTPUT, so selecting by c_cnt keeps data stable under stalls.
  assign m_axis_c_tvalid = c_valid;
  assign m_axis_c_tdata  = c_valid ? acc[c_cnt] : '0;
  assign m_axis_c_tlast  = c_valid && c_final;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid    <= 1'b0;
      c_cnt      <= '0;
      done_pulse <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      irq        <= 1'b0;
    end else begin
      done_pulse <= c_hs && c_final;
      if (state == COMPUTE && k_final) c_valid <= 1'b1;
      else if (c_hs && c_final)        c_valid <= 1'b0;
      if (c_hs) c_cnt <= c_final ? '0 : c_cnt + CI_W'(1);
      done_reg <= done_pulse | (done_reg & ~clr_done);
      err_reg  <= (|err_event) | (err_reg & ~clr_done);
      irq      <= done_reg & irq_en;
    end
  end

endmodule

// File: tb/tb_matmul_tile_engine.sv
// Self-checking bench for matmul_tile_engine: table-driven tiles, corner sequences, random tiles vs a model.
module tb_matmul_tile_engine;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int M      = 2;
  localparam int N      = 2;
  localparam int K_MAX  = 8;
  localparam int CK_W   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] s_axis_a_tdata = '0;
  logic              s_axis_a_tvalid = 1'b0;
  logic              s_axis_a_tready;
  logic              s_axis_a_tlast = 1'b0;
  logic [DATA_W-1:0] s_axis_b_tdata = '0;
  logic              s_axis_b_tvalid = 1'b0;
  logic              s_axis_b_tready;
  logic              s_axis_b_tlast = 1'b0;
  logic [ACC_W-1:0]  m_axis_c_tdata;
  logic              m_axis_c_tvalid;
  logic              m_axis_c_tready = 1'b0;
  logic              m_axis_c_tlast;
  logic [CK_W-1:0]   cfg_k = '0;
  logic              start = 1'b0;
  logic              clr_done = 1'b0;
  logic              irq_en = 1'b0;
  logic              busy, done_pulse, done_reg, err_reg, irq;

  matmul_tile_engine #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .M(M), .N(N), .K_MAX(K_MAX)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis_a_tdata  (s_axis_a_tdata),
    .s_axis_a_tvalid (s_axis_a_tvalid),
    .s_axis_a_tready (s_axis_a_tready),
    .s_axis_a_tlast  (s_axis_a_tlast),
    .s_axis_b_tdata  (s_axis_b_tdata),
    .s_axis_b_tvalid (s_axis_b_tvalid),
    .s_axis_b_tready (s_axis_b_tready),
    .s_axis_b_tlast  (s_axis_b_tlast),
    .m_axis_c_tdata  (m_axis_c_tdata),
    .m_axis_c_tvalid (m_axis_c_tvalid),
    .m_axis_c_tready (m_axis_c_tready),
    .m_axis_c_tlast  (m_axis_c_tlast),
    .cfg_k           (cfg_k),
    .start           (start),
    .clr_done        (clr_done),
    .irq_en          (irq_en),
    .busy            (busy),
    .done_pulse      (done_pulse),
    .done_reg        (done_reg),
    .err_reg         (err_reg),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cyc = 0;

  int a_mat [M][K_MAX];
  int b_mat [K_MAX][N];
  int exp_c [M*N];

  typedef struct {
    int k;
    int a_base, a_step, b_base, b_step;
    int ready_mode;
    int bad_a;
    int err;
    int c0, c1, c2, c3;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference: C = A x B with plain 32-bit integer arithmetic (wraps like the accumulators).
  task automatic model(input int k);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        int s = 0;
        for (int p = 0; p < k; p++) s += a_mat[i][p] * b_mat[p][j];
        exp_c[i*N+j] = s;
      end
  endtask

  task automatic fill_pattern(input int k, input int ab, input int as, input int bb, input int bs);
    for (int i = 0; i < M; i++)
      for (int c = 0; c < k; c++) a_mat[i][c] = ab + as * (i * k + c);
    for (int r = 0; r < k; r++)
      for (int c = 0; c < N; c++) b_mat[r][c] = bb + bs * (r * N + c);
  endtask

  task automatic fill_random(input int k);
    logic [15:0] t;
    for (int i = 0; i < M; i++)
      for (int c = 0; c < k; c++) begin t = 16'($urandom); a_mat[i][c] = int'($signed(t)); end
    for (int r = 0; r < k; r++)
      for (int c = 0; c < N; c++) begin t = 16'($urandom); b_mat[r][c] = int'($signed(t)); end
  endtask

  task automatic send_beat(input bit is_b, input int data, input bit last, input bit gaps);
    int guard = 0;
    int g2 = 0;
    while (gaps && $urandom_range(0, 2) == 0 && g2 < 4) begin @(negedge clk); g2++; end
    if (is_b) begin
      s_axis_b_tdata = 16'(data); s_axis_b_tlast = last; s_axis_b_tvalid = 1'b1;
    end else begin
      s_axis_a_tdata = 16'(data); s_axis_a_tlast = last; s_axis_a_tvalid = 1'b1;
    end
    while (!(is_b ? s_axis_b_tready : s_axis_a_tready) && guard < 200) begin
      @(negedge clk); guard++;
    end
    if (guard >= 200) check("ready_timeout", 0, 1);
    @(negedge clk);
    s_axis_a_tvalid = 1'b0; s_axis_a_tlast = 1'b0;
    s_axis_b_tvalid = 1'b0; s_axis_b_tlast = 1'b0;
  endtask

  task automatic apply_stimulus(input int k, input int bad_a, input bit gaps);
    cfg_k = CK_W'(k);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < M * k; b++)
      send_beat(1'b0, a_mat[b / k][b % k], (bad_a >= 0) ? (b == bad_a) : (b == M * k - 1), gaps);
    for (int b = 0; b < k * N; b++)
      send_beat(1'b1, b_mat[b / N][b % N], b == k * N - 1, gaps);
  endtask

  task automatic check_output(input int k, input int mode, input bit check_lat);
    int idx = 0;
    int guard = 0;
    int first = -1;
    bit stalled = 1'b0;
    int held_d = 0;
    int held_l = 0;
    while (idx < M * N && guard < 400) begin
      case (mode)
        0:       m_axis_c_tready = 1'b1;
        1:       m_axis_c_tready = (guard % 4 == 0) || (guard % 4 == 3);
        default: m_axis_c_tready = 1'($urandom_range(0, 1));
      endcase
      if (m_axis_c_tvalid) begin
        if (first < 0) first = cyc;
        if (stalled) begin
          check("stall_tdata", int'($signed(m_axis_c_tdata)), held_d);
          check("stall_tlast", int'(m_axis_c_tlast), held_l);
        end
        if (m_axis_c_tready) begin
          check("c_data", int'($signed(m_axis_c_tdata)), exp_c[idx]);
          check("c_tlast", int'(m_axis_c_tlast), int'(idx == M * N - 1));
          idx++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_d  = int'($signed(m_axis_c_tdata));
          held_l  = int'(m_axis_c_tlast);
        end
      end
      @(negedge clk);
      guard++;
    end
    if (idx < M * N) check("c_timeout", idx, M * N);
    m_axis_c_tready = 1'b0;
    if (check_lat) check("latency", first - start_cyc, 1 + M * k + k * N + k);
    check("tvalid_drop", int'(m_axis_c_tvalid), 0);
    check("done_pulse_hi", int'(done_pulse), 1);
    check("busy_idle", int'(busy), 0);
    @(negedge clk);
    check("done_pulse_lo", int'(done_pulse), 0);
    check("done_reg", int'(done_reg), 1);
    @(negedge clk);
    check("irq", int'(irq), int'(irq_en));
  endtask

  task automatic clear_status();
    clr_done = 1'b1;
    @(negedge clk);
    clr_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_a_tready"}, int'(s_axis_a_tready), 0);
    check({tag, "_b_tready"}, int'(s_axis_b_tready), 0);
    check({tag, "_tvalid"}, int'(m_axis_c_tvalid), 0);
    check({tag, "_tdata"}, int'(m_axis_c_tdata), 0);
    check({tag, "_tlast"}, int'(m_axis_c_tlast), 0);
    check({tag, "_done_pulse"}, int'(done_pulse), 0);
    check({tag, "_done_reg"}, int'(done_reg), 0);
    check({tag, "_err_reg"}, int'(err_reg), 0);
    check({tag, "_irq"}, int'(irq), 0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{k:2, a_base:1,  a_step:1, b_base:5,  b_step:1,  ready_mode:0, bad_a:-1, err:0,
                c0:19,  c1:22,  c2:43, c3:50};
    vecs[1] = '{k:2, a_base:1,  a_step:1, b_base:5,  b_step:1,  ready_mode:1, bad_a:-1, err:0,
                c0:19,  c1:22,  c2:43, c3:50};
    vecs[2] = '{k:8, a_base:-1, a_step:0, b_base:3,  b_step:0,  ready_mode:0, bad_a:-1, err:0,
                c0:-24, c1:-24, c2:-24, c3:-24};
    vecs[3] = '{k:2, a_base:1,  a_step:1, b_base:5,  b_step:1,  ready_mode:0, bad_a:1,  err:1,
                c0:19,  c1:22,  c2:43, c3:50};
    vecs[4] = '{k:3, a_base:-3, a_step:2, b_base:10, b_step:-4, ready_mode:2, bad_a:-1, err:0,
                c0:-38, c1:-26, c2:-2, c3:-62};

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 5; r++) begin
      irq_en = (r >= 3);
      clear_status();
      fill_pattern(vecs[r].k, vecs[r].a_base, vecs[r].a_step, vecs[r].b_base, vecs[r].b_step);
      exp_c[0] = vecs[r].c0; exp_c[1] = vecs[r].c1; exp_c[2] = vecs[r].c2; exp_c[3] = vecs[r].c3;
      apply_stimulus(vecs[r].k, vecs[r].bad_a, 1'b0);
      check_output(vecs[r].k, vecs[r].ready_mode, 1'b1);
      check("err_reg_after_tile", int'(err_reg), vecs[r].err);
    end

    // Reset in the middle of LOAD_B, with done_reg/irq still set from the last tile.
    fill_pattern(2, 1, 1, 5, 1);
    cfg_k = CK_W'(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < M * 2; b++) send_beat(1'b0, a_mat[b / 2][b % 2], b == M * 2 - 1, 1'b0);
    send_beat(1'b1, b_mat[0][0], 1'b0, 1'b0);
    check("mid_load_b_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    irq_en = 1'b1;
    fill_pattern(2, 1, 1, 5, 1);
    exp_c[0] = 19; exp_c[1] = 22; exp_c[2] = 43; exp_c[3] = 50;
    apply_stimulus(2, -1, 1'b0);
    check_output(2, 0, 1'b1);
    irq_en = 1'b0;
    @(negedge clk);
    check("irq_follows_en", int'(irq), 0);

    // Configuration errors: K of zero and K above the maximum.
    clear_status();
    cfg_k = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cfg0_busy", int'(busy), 0);
    check("cfg0_a_tready", int'(s_axis_a_tready), 0);
    check("cfg0_err", int'(err_reg), 1);
    clear_status();
    check("cfg0_err_cleared", int'(err_reg), 0);
    cfg_k = CK_W'(K_MAX + 1);
    start = 1'b1;
    clr_done = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clr_done = 1'b0;
    check("cfg_over_set_wins", int'(err_reg), 1);
    check("cfg_over_busy", int'(busy), 0);
    clear_status();

    for (int r = 0; r < 6; r++) begin
      int k;
      k = $urandom_range(1, K_MAX);
      irq_en = 1'($urandom_range(0, 1));
      clear_status();
      fill_random(k);
      model(k);
      apply_stimulus(k, -1, 1'b1);
      check_output(k, 2, 1'b0);
      check("rand_err_reg", int'(err_reg), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_tile_engine.md
Name: matmul_tile_engine

Overview:
Parametrised M x N output-tile matrix-multiply engine for the AXI matrix accelerator datapath.
- Loads an M x K tile of A and a K x N tile of B over two AXI-Stream slaves, then runs K parallel MAC steps across an M*N accumulator array.
- Streams C row-major over an AXI-Stream master with full backpressure.
- Reports completion through a done pulse, a sticky done bit and an irq. Reports framing and config errors through a sticky error bit.

Parameters:
DATA_W, 16, signed element width of A and B
ACC_W, 32, signed accumulator and C element width
M, 2, rows of A and C
N, 2, columns of B and C
K_MAX, 8, maximum inner dimension; CK_W = $clog2(K_MAX+1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_axis_a_tdata  in  DATA_W  A element, row-major
s_axis_a_tvalid  in  1  A valid
s_axis_a_tready  out  1  A ready
s_axis_a_tlast  in  1  A last beat
s_axis_b_tdata  in  DATA_W  B element, row-major
s_axis_b_tvalid  in  1  B valid
s_axis_b_tready  out  1  B ready
s_axis_b_tlast  in  1  B last beat
m_axis_c_tdata  out  ACC_W  C element, row-major
m_axis_c_tvalid  out  1  C valid
m_axis_c_tready  in  1  C ready
m_axis_c_tlast  out  1  C last beat
cfg_k  in  CK_W  inner dimension K, sampled on accepted start
start  in  1  start request, sampled in IDLE only
clr_done  in  1  software clear for done_reg and err_reg
irq_en  in  1  interrupt enable
busy  out  1  high whenever state != IDLE
done_pulse  out  1  one-cycle completion event
done_reg  out  1  sticky completion status
err_reg  out  1  sticky error status
irq  out  1  done_reg & irq_en, registered

Behaviour:
- Reset: state=IDLE; all counters, accumulators, buffers and output registers = 0; every output = 0.
- States: IDLE, LOAD_A, LOAD_B, COMPUTE, OUTPUT.
- IDLE:
  - start with 1 <= cfg_k <= K_MAX latches k_r = cfg_k, clears the accumulators, and moves to LOAD_A next cycle.
  - start with cfg_k == 0 or cfg_k > K_MAX sets err_reg and stays in IDLE.
  - start outside IDLE is ignored.
- LOAD_A:
  - s_axis_a_tready = 1 only in this state.
  - The handshake writes A_buf[row][col]. col wraps at k_r-1 and row then increments.
  - After M*k_r beats, move to LOAD_B.
  - If tlast does not coincide exactly with the final beat, set err_reg. Transitions are count-driven only; tlast never changes the FSM.
- LOAD_B:
  - Same rules as LOAD_A, writing B_buf[row][col] with k_r rows x N cols; k_r*N beats.
  - Then move to COMPUTE.
- COMPUTE:
  - Runs exactly k_r cycles, k_cnt = 0..k_r-1.
  - Each cycle, all i,j in parallel: C[i][j] <= C[i][j] + sext(A[i][k_cnt] * B[k_cnt][j]). The product is signed 2*DATA_W; it is sign-extended or truncated to ACC_W, and the sum wraps modulo 2^ACC_W.
  - After the step with k_cnt == k_r-1, move to OUTPUT.
- OUTPUT:
  - Registered output stage drives element c_cnt. m_axis_c_tvalid rises on the first OUTPUT cycle.
  - tdata and tlast hold stable while tvalid && !tready.
  - On each handshake, the next element loads in the same cycle (full throughput, no bubble).
  - tlast = 1 only on element M*N-1.
  - On the final handshake: tvalid drops next cycle, state returns to IDLE, and done_pulse = 1 for exactly one cycle (registered).
- Status:
  - done_reg sets on done_pulse. err_reg sets on any error event.
  - Both clear on clr_done. A set event wins over a simultaneous clr_done.
  - irq = registered (done_reg & irq_en).
- Latency: start accepted at cycle t gives tready_a at t+1. Zero-stall total from start to first C valid = 1 + M*K + K*N + K cycles.
- Asynchronous reset mid-operation aborts immediately to the reset values. Partial tile data is discarded.
- Input data arriving outside its LOAD state is never accepted (tready low).

Decomposition:
- matmul_pkg holds state_t, the CK_W computation function and the error-cause localparams.
- One sub-module, matmul_pe: a single accumulator cell with inputs a, b, clear and en, and output acc. It is instantiated M*N times via generate.

Test Plan:
1. M=N=2, K=2: A={1,2,3,4}, B={5,6,7,8}, tready=1 -> C = 19,22,43,50; tlast on 4th beat; done_pulse 1 cycle; done_reg=1.
2. Same stimulus with tready toggling 1-0-0-1 -> identical C; tdata/tlast stable during stalls; exactly 4 handshakes.
3. K=K_MAX=8, A all -1, B all 3 -> every C = -24; COMPUTE lasts exactly 8 cycles.
4. cfg_k=0 with start -> stays IDLE, err_reg=1, no tready; then clr_done -> err_reg=0.
5. A tlast asserted on beat 2 of 4 -> err_reg=1, FSM still consumes 4 beats, C still correct.
6. Reset asserted mid LOAD_B -> all outputs 0 and IDLE; a following normal run matches scenario 1; irq follows done_reg only when irq_en=1.
